// File: rtl/ariane_axi_mem_pkg.sv
// Shared encodings, FSM states and burst context for the AXI memory responder.
package ariane_axi_mem_pkg;

  localparam int CTX_ADDR_W = 64;
  localparam int CTX_ID_W   = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

  // err marks a burst-wide error (WRAP, oversize, atomic): no beat touches memory.
  typedef struct packed {
    logic [CTX_ID_W-1:0]   id;
    logic [CTX_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  err;
    logic [7:0]            cnt;
  } burst_ctx_t;

  // Address of the following beat: FIXED stays put, anything else steps by 2^size.
  function automatic logic [CTX_ADDR_W-1:0] next_addr(input logic [CTX_ADDR_W-1:0] addr,
                                                      input logic [2:0]            size,
                                                      input logic [1:0]            burst);
    if (burst == BURST_FIXED) return addr;
    return addr + (CTX_ADDR_W'(1) << size);
  endfunction

endpackage

// File: rtl/ariane_axi_mem_array.sv
// Word-wide storage with one byte-strobed write port and one registered read port.
module ariane_axi_mem_array #(
  parameter int WORDS  = 1024,
  parameter int DATA_W = 64,
  localparam int IDX_W  = $clog2(WORDS),
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  // Strobed byte write; contents are deliberately never reset.
  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Synchronous read; holds its value when re is low so a stalled beat stays stable.
  always_ff @(posedge clk_i) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ariane_axi_mem_responder.sv
// AXI4 responder backed by ariane_axi_mem_array, one outstanding burst per direction.
//
// state  | meaning
// W_IDLE | waiting for AW, aw_ready high
// W_DATA | accepting W beats, w_ready high
// W_RESP | presenting B until b_ready
// R_IDLE | waiting for AR, ar_ready high
// R_DATA | presenting R beats, next beat prefetched on each handshake
module ariane_axi_mem_responder
  import ariane_axi_mem_pkg::*;
#(
  parameter int AXI_ADDRESS_WIDTH = 64,
  parameter int AXI_DATA_WIDTH    = 64,
  parameter int AXI_ID_WIDTH      = 4,
  parameter int AXI_USER_WIDTH    = 1,
  parameter int MEM_WORDS         = 1024,
  parameter logic [AXI_ADDRESS_WIDTH-1:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         axi_req_i_aw_valid,
  input  logic [AXI_ID_WIDTH-1:0]      axi_req_i_aw_bits_id,
  input  logic [AXI_ADDRESS_WIDTH-1:0] axi_req_i_aw_bits_addr,
  input  logic [7:0]                   axi_req_i_aw_bits_len,
  input  logic [2:0]                   axi_req_i_aw_bits_size,
  input  logic [1:0]                   axi_req_i_aw_bits_burst,
  input  logic                         axi_req_i_aw_bits_lock,
  input  logic [3:0]                   axi_req_i_aw_bits_cache,
  input  logic [2:0]                   axi_req_i_aw_bits_prot,
  input  logic [3:0]                   axi_req_i_aw_bits_qos,
  input  logic [3:0]                   axi_req_i_aw_bits_region,
  input  logic [5:0]                   axi_req_i_aw_bits_atop,
  input  logic [AXI_USER_WIDTH-1:0]    axi_req_i_aw_bits_user,
  output logic                         axi_resp_o_aw_ready,
  input  logic                         axi_req_i_w_valid,
  input  logic [AXI_DATA_WIDTH-1:0]    axi_req_i_w_bits_data,
  input  logic [AXI_DATA_WIDTH/8-1:0]  axi_req_i_w_bits_strb,
  input  logic                         axi_req_i_w_bits_last,
  input  logic [AXI_USER_WIDTH-1:0]    axi_req_i_w_bits_user,
  output logic                         axi_resp_o_w_ready,
  output logic                         axi_resp_o_b_valid,
  output logic [AXI_ID_WIDTH-1:0]      axi_resp_o_b_bits_id,
  output logic [1:0]                   axi_resp_o_b_bits_resp,
  output logic [AXI_USER_WIDTH-1:0]    axi_resp_o_b_bits_user,
  input  logic                         axi_req_i_b_ready,
  input  logic                         axi_req_i_ar_valid,
  input  logic [AXI_ID_WIDTH-1:0]      axi_req_i_ar_bits_id,
  input  logic [AXI_ADDRESS_WIDTH-1:0] axi_req_i_ar_bits_addr,
  input  logic [7:0]                   axi_req_i_ar_bits_len,
  input  logic [2:0]                   axi_req_i_ar_bits_size,
  input  logic [1:0]                   axi_req_i_ar_bits_burst,
  input  logic                         axi_req_i_ar_bits_lock,
  input  logic [3:0]                   axi_req_i_ar_bits_cache,
  input  logic [2:0]                   axi_req_i_ar_bits_prot,
  input  logic [3:0]                   axi_req_i_ar_bits_qos,
  input  logic [3:0]                   axi_req_i_ar_bits_region,
  input  logic [AXI_USER_WIDTH-1:0]    axi_req_i_ar_bits_user,
  output logic                         axi_resp_o_ar_ready,
  output logic                         axi_resp_o_r_valid,
  output logic [AXI_ID_WIDTH-1:0]      axi_resp_o_r_bits_id,
  output logic [AXI_DATA_WIDTH-1:0]    axi_resp_o_r_bits_data,
  output logic [1:0]                   axi_resp_o_r_bits_resp,
  output logic                         axi_resp_o_r_bits_last,
  output logic [AXI_USER_WIDTH-1:0]    axi_resp_o_r_bits_user,
  input  logic                         axi_req_i_r_ready
);

  localparam int OFF_W = $clog2(AXI_DATA_WIDTH / 8);
  localparam int IDX_W = $clog2(MEM_WORDS);

  // Below the base or past the last word: the beat is dropped (write) or zeroed (read).
  function automatic logic addr_bad(input logic [AXI_ADDRESS_WIDTH-1:0] a);
    return (a < BASE_ADDR) || (((a - BASE_ADDR) >> (OFF_W + IDX_W)) != '0);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDRESS_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> OFF_W);
  endfunction

  wstate_e    w_state, w_next;
  rstate_e    r_state, r_next;
  burst_ctx_t w_ctx, r_ctx;
  logic       w_err;
  logic       aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic       mem_we, mem_re;
  logic [IDX_W-1:0]          mem_raddr;
  logic [AXI_DATA_WIDTH-1:0] mem_rdata;

  logic aw_hs, w_hs, ar_hs, r_hs;
  logic aw_burst_err, ar_burst_err, w_is_last, r_is_last, w_beat_bad, r_beat_bad;
  logic [AXI_ADDRESS_WIDTH-1:0] r_addr_nxt;

  assign aw_hs = aw_ready & axi_req_i_aw_valid;
  assign w_hs  = w_ready  & axi_req_i_w_valid;
  assign ar_hs = ar_ready & axi_req_i_ar_valid;
  assign r_hs  = r_valid  & axi_req_i_r_ready;

  assign aw_burst_err = (axi_req_i_aw_bits_burst == BURST_WRAP) ||
                        (axi_req_i_aw_bits_size > 3'(OFF_W)) || (axi_req_i_aw_bits_atop != '0);
  assign ar_burst_err = (axi_req_i_ar_bits_burst == BURST_WRAP) ||
                        (axi_req_i_ar_bits_size > 3'(OFF_W));
  assign w_is_last  = (w_ctx.cnt == w_ctx.len);
  assign r_is_last  = (r_ctx.cnt == r_ctx.len);
  assign w_beat_bad = addr_bad(w_ctx.addr);
  assign r_beat_bad = r_ctx.err | addr_bad(r_ctx.addr);
  assign r_addr_nxt = next_addr(r_ctx.addr, r_ctx.size, r_ctx.burst);

  // Write channel next state and handshakes; reset forces everything quiet.
  always_comb begin
    w_next   = w_state;
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    mem_we   = 1'b0;
    case (w_state)
      W_IDLE: begin
        aw_ready = 1'b1;
        if (axi_req_i_aw_valid) w_next = W_DATA;
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (axi_req_i_w_valid) begin
          mem_we = ~w_ctx.err & ~w_beat_bad;
          if (w_is_last) w_next = W_RESP;
        end
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (axi_req_i_b_ready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
    if (rst_i) begin
      w_next   = W_IDLE;
      aw_ready = 1'b0;
      w_ready  = 1'b0;
      b_valid  = 1'b0;
      mem_we   = 1'b0;
    end
  end

  // Write state and burst context; w_err accumulates any reason for SLVERR.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state <= W_IDLE;
      w_ctx   <= '0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        w_ctx <= '{id: axi_req_i_aw_bits_id, addr: axi_req_i_aw_bits_addr,
                   len: axi_req_i_aw_bits_len, size: axi_req_i_aw_bits_size,
                   burst: axi_req_i_aw_bits_burst, err: aw_burst_err, cnt: 8'd0};
        w_err <= aw_burst_err;
      end
      if (w_hs) begin
        w_ctx.addr <= next_addr(w_ctx.addr, w_ctx.size, w_ctx.burst);
        w_ctx.cnt  <= w_ctx.cnt + 8'd1;
        if (w_beat_bad || (axi_req_i_w_bits_last != w_is_last)) w_err <= 1'b1;
      end
    end
  end

  // Read channel next state; the memory read for the next beat is issued on each handshake.
  always_comb begin
    r_next    = r_state;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    mem_re    = 1'b0;
    mem_raddr = word_idx(axi_req_i_ar_bits_addr);
    case (r_state)
      R_IDLE: begin
        ar_ready = 1'b1;
        if (axi_req_i_ar_valid) begin
          r_next = R_DATA;
          mem_re = 1'b1;
        end
      end
      R_DATA: begin
        r_valid   = 1'b1;
        mem_raddr = word_idx(r_addr_nxt);
        if (axi_req_i_r_ready) begin
          if (r_is_last) r_next = R_IDLE;
          else           mem_re = 1'b1;
        end
      end
      default: r_next = R_IDLE;
    endcase
    if (rst_i) begin
      r_next   = R_IDLE;
      ar_ready = 1'b0;
      r_valid  = 1'b0;
      mem_re   = 1'b0;
    end
  end

  // Read state and burst context.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= R_IDLE;
      r_ctx   <= '0;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        r_ctx <= '{id: axi_req_i_ar_bits_id, addr: axi_req_i_ar_bits_addr,
                   len: axi_req_i_ar_bits_len, size: axi_req_i_ar_bits_size,
                   burst: axi_req_i_ar_bits_burst, err: ar_burst_err, cnt: 8'd0};
      end
      if (r_hs) begin
        r_ctx.addr <= r_addr_nxt;
        r_ctx.cnt  <= r_ctx.cnt + 8'd1;
      end
    end
  end

  ariane_axi_mem_array #(.WORDS(MEM_WORDS), .DATA_W(AXI_DATA_WIDTH)) u_array (
    .clk_i (clk_i),
    .we    (mem_we),
    .waddr (word_idx(w_ctx.addr)),
    .wdata (axi_req_i_w_bits_data),
    .wstrb (axi_req_i_w_bits_strb),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  assign axi_resp_o_aw_ready    = aw_ready;
  assign axi_resp_o_w_ready     = w_ready;
  assign axi_resp_o_ar_ready    = ar_ready;
  assign axi_resp_o_b_valid     = b_valid;
  assign axi_resp_o_b_bits_id   = b_valid ? w_ctx.id : '0;
  assign axi_resp_o_b_bits_resp = b_valid ? (w_err ? RESP_SLVERR : RESP_OKAY) : RESP_OKAY;
  assign axi_resp_o_b_bits_user = '0;
  assign axi_resp_o_r_valid     = r_valid;
  assign axi_resp_o_r_bits_id   = r_valid ? r_ctx.id : '0;
  assign axi_resp_o_r_bits_data = (r_valid && !r_beat_bad) ? mem_rdata : '0;
  assign axi_resp_o_r_bits_resp = r_valid ? (r_beat_bad ? RESP_SLVERR : RESP_OKAY) : RESP_OKAY;
  assign axi_resp_o_r_bits_last = r_valid & r_is_last;
  assign axi_resp_o_r_bits_user = '0;

  logic unused_inputs;
  assign unused_inputs = ^{axi_req_i_aw_bits_lock, axi_req_i_aw_bits_cache, axi_req_i_aw_bits_prot,
                           axi_req_i_aw_bits_qos, axi_req_i_aw_bits_region, axi_req_i_aw_bits_user,
                           axi_req_i_w_bits_user, axi_req_i_ar_bits_lock, axi_req_i_ar_bits_cache,
                           axi_req_i_ar_bits_prot, axi_req_i_ar_bits_qos, axi_req_i_ar_bits_region,
                           axi_req_i_ar_bits_user};

endmodule

// File: tb/tb_ariane_axi_mem_responder.sv
// Directed bench for ariane_axi_mem_responder.
module tb_ariane_axi_mem_responder;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        aw_valid = 0;
  logic [3:0]  aw_id = 0;
  logic [63:0] aw_addr = 0;
  logic [7:0]  aw_len = 0;
  logic [2:0]  aw_size = 0;
  logic [1:0]  aw_burst = 0;
  logic [5:0]  aw_atop = 0;
  logic        aw_ready;
  logic        w_valid = 0;
  logic [63:0] w_data = 0;
  logic [7:0]  w_strb = 0;
  logic        w_last = 0;
  logic        w_ready;
  logic        b_valid;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic [0:0]  b_user;
  logic        b_ready = 0;
  logic        ar_valid = 0;
  logic [3:0]  ar_id = 0;
  logic [63:0] ar_addr = 0;
  logic [7:0]  ar_len = 0;
  logic [2:0]  ar_size = 0;
  logic [1:0]  ar_burst = 0;
  logic        ar_ready;
  logic        r_valid;
  logic [3:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic [0:0]  r_user;
  logic        r_ready = 0;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] wd [8];
  logic [7:0]  ws [8];
  logic [63:0] ed [8];
  logic [1:0]  er [8];

  always #5 clk = ~clk;

  ariane_axi_mem_responder dut (
    .clk_i(clk), .rst_i(rst),
    .axi_req_i_aw_valid(aw_valid), .axi_req_i_aw_bits_id(aw_id), .axi_req_i_aw_bits_addr(aw_addr),
    .axi_req_i_aw_bits_len(aw_len), .axi_req_i_aw_bits_size(aw_size),
    .axi_req_i_aw_bits_burst(aw_burst), .axi_req_i_aw_bits_lock(1'b0),
    .axi_req_i_aw_bits_cache(4'd0), .axi_req_i_aw_bits_prot(3'd0), .axi_req_i_aw_bits_qos(4'd0),
    .axi_req_i_aw_bits_region(4'd0), .axi_req_i_aw_bits_atop(aw_atop),
    .axi_req_i_aw_bits_user(1'b0), .axi_resp_o_aw_ready(aw_ready),
    .axi_req_i_w_valid(w_valid), .axi_req_i_w_bits_data(w_data), .axi_req_i_w_bits_strb(w_strb),
    .axi_req_i_w_bits_last(w_last), .axi_req_i_w_bits_user(1'b0), .axi_resp_o_w_ready(w_ready),
    .axi_resp_o_b_valid(b_valid), .axi_resp_o_b_bits_id(b_id), .axi_resp_o_b_bits_resp(b_resp),
    .axi_resp_o_b_bits_user(b_user), .axi_req_i_b_ready(b_ready),
    .axi_req_i_ar_valid(ar_valid), .axi_req_i_ar_bits_id(ar_id), .axi_req_i_ar_bits_addr(ar_addr),
    .axi_req_i_ar_bits_len(ar_len), .axi_req_i_ar_bits_size(ar_size),
    .axi_req_i_ar_bits_burst(ar_burst), .axi_req_i_ar_bits_lock(1'b0),
    .axi_req_i_ar_bits_cache(4'd0), .axi_req_i_ar_bits_prot(3'd0), .axi_req_i_ar_bits_qos(4'd0),
    .axi_req_i_ar_bits_region(4'd0), .axi_req_i_ar_bits_user(1'b0),
    .axi_resp_o_ar_ready(ar_ready),
    .axi_resp_o_r_valid(r_valid), .axi_resp_o_r_bits_id(r_id), .axi_resp_o_r_bits_data(r_data),
    .axi_resp_o_r_bits_resp(r_resp), .axi_resp_o_r_bits_last(r_last),
    .axi_resp_o_r_bits_user(r_user), .axi_req_i_r_ready(r_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_aw_ready"}, 64'(aw_ready), 64'd0);
    chk({tag, "_w_ready"},  64'(w_ready),  64'd0);
    chk({tag, "_ar_ready"}, 64'(ar_ready), 64'd0);
    chk({tag, "_b_valid"},  64'(b_valid),  64'd0);
    chk({tag, "_r_valid"},  64'(r_valid),  64'd0);
    chk({tag, "_r_data"},   r_data,        64'd0);
    chk({tag, "_b_id"},     64'(b_id),     64'd0);
  endtask

  task automatic write_burst(input string tag, input logic [3:0] id, input logic [63:0] addr,
                             input logic [7:0] len, input logic [1:0] burst, input logic [5:0] atop,
                             input int last_pos, input logic [1:0] exp_resp);
    aw_valid = 1; aw_id = id; aw_addr = addr; aw_len = len; aw_size = 3'd3;
    aw_burst = burst; aw_atop = atop;
    @(negedge clk); chk({tag, "_aw_ready"}, 64'(aw_ready), 64'd1);
    @(posedge clk); #1 aw_valid = 0;
    for (int k = 0; k <= int'(len); k++) begin
      w_valid = 1; w_data = wd[k]; w_strb = ws[k]; w_last = (k == last_pos);
      @(negedge clk); chk({tag, "_w_ready"}, 64'(w_ready), 64'd1);
      @(posedge clk); #1;
    end
    w_valid = 0; w_last = 0; b_ready = 1;
    @(negedge clk);
    chk({tag, "_b_valid"}, 64'(b_valid), 64'd1);
    chk({tag, "_b_id"},    64'(b_id),    64'(id));
    chk({tag, "_b_resp"},  64'(b_resp),  64'(exp_resp));
    chk({tag, "_b_user"},  64'(b_user),  64'd0);
    @(posedge clk); #1 b_ready = 0;
    @(negedge clk); chk({tag, "_b_done"}, 64'(b_valid), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic read_burst(input string tag, input logic [3:0] id, input logic [63:0] addr,
                            input logic [7:0] len, input logic [1:0] burst, input logic stall);
    r_ready = ~stall;
    ar_valid = 1; ar_id = id; ar_addr = addr; ar_len = len; ar_size = 3'd3; ar_burst = burst;
    @(negedge clk); chk({tag, "_ar_ready"}, 64'(ar_ready), 64'd1);
    @(posedge clk); #1 ar_valid = 0;
    for (int k = 0; k <= int'(len); k++) begin
      if (stall) begin
        @(negedge clk);
        chk($sformatf("%s_stall_valid%0d", tag, k), 64'(r_valid), 64'd1);
        chk($sformatf("%s_stall_data%0d", tag, k),  r_data, ed[k]);
        chk($sformatf("%s_stall_last%0d", tag, k),  64'(r_last), 64'(k == int'(len)));
        @(posedge clk); #1 r_ready = 1;
      end
      @(negedge clk);
      chk($sformatf("%s_valid%0d", tag, k), 64'(r_valid), 64'd1);
      chk($sformatf("%s_data%0d", tag, k),  r_data, ed[k]);
      chk($sformatf("%s_resp%0d", tag, k),  64'(r_resp), 64'(er[k]));
      chk($sformatf("%s_last%0d", tag, k),  64'(r_last), 64'(k == int'(len)));
      chk($sformatf("%s_id%0d", tag, k),    64'(r_id), 64'(id));
      chk($sformatf("%s_user%0d", tag, k),  64'(r_user), 64'd0);
      @(posedge clk); #1 if (stall) r_ready = 0;
    end
    r_ready = 0;
    @(negedge clk); chk({tag, "_r_done"}, 64'(r_valid), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 8; k++) begin ws[k] = 8'hFF; er[k] = 2'b00; end

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk); chk_idle_outputs("reset");
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rel_aw_ready", 64'(aw_ready), 64'd1);
    chk("rel_ar_ready", 64'(ar_ready), 64'd1);
    @(posedge clk); #1;

    // single beat write and readback
    wd[0] = 64'hDEAD_BEEF_0123_4567;
    write_burst("wr1", 4'd3, BASE + 64'h8, 8'd0, 2'b01, 6'd0, 0, 2'b00);
    ed[0] = 64'hDEAD_BEEF_0123_4567;
    read_burst("rd1", 4'd5, BASE + 64'h8, 8'd0, 2'b01, 1'b0);

    // INCR len 3, then overwrite with a half strobe on beat 2
    for (int k = 0; k < 4; k++) wd[k] = {32'hAAAA_AAA0 + 32'(k), 32'hBBBB_BBB0 + 32'(k)};
    write_burst("wr2a", 4'd1, BASE + 64'h40, 8'd3, 2'b01, 6'd0, 3, 2'b00);
    for (int k = 0; k < 4; k++) wd[k] = {32'hCCCC_CCC0 + 32'(k), 32'hDDDD_DDD0 + 32'(k)};
    ws[2] = 8'h0F;
    write_burst("wr2b", 4'd2, BASE + 64'h40, 8'd3, 2'b01, 6'd0, 3, 2'b00);
    ws[2] = 8'hFF;
    ed[0] = 64'hCCCC_CCC0_DDDD_DDD0; ed[1] = 64'hCCCC_CCC1_DDDD_DDD1;
    ed[2] = 64'hAAAA_AAA2_DDDD_DDD2; ed[3] = 64'hCCCC_CCC3_DDDD_DDD3;
    read_burst("rd2", 4'd7, BASE + 64'h40, 8'd3, 2'b01, 1'b0);

    // len 7 read with r_ready toggled
    for (int k = 0; k < 8; k++) wd[k] = 64'h5A5A_0000_0000_0000 + 64'(k);
    write_burst("wr3", 4'd4, BASE + 64'h100, 8'd7, 2'b01, 6'd0, 7, 2'b00);
    for (int k = 0; k < 8; k++) ed[k] = 64'h5A5A_0000_0000_0000 + 64'(k);
    read_burst("rd3", 4'd9, BASE + 64'h100, 8'd7, 2'b01, 1'b1);

    // write below base, atomic write
    wd[0] = 64'h1234_5678_9ABC_DEF0;
    write_burst("wr4a", 4'd6, BASE, 8'd0, 2'b01, 6'd0, 0, 2'b00);
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    write_burst("wr4b", 4'd8, BASE - 64'h8, 8'd0, 2'b01, 6'd0, 0, 2'b10);
    write_burst("wr4c", 4'd10, BASE + 64'h48, 8'd0, 2'b01, 6'h20, 0, 2'b10);
    ed[0] = 64'h1234_5678_9ABC_DEF0; ed[1] = 64'hDEAD_BEEF_0123_4567;
    read_burst("rd4a", 4'd1, BASE, 8'd1, 2'b01, 1'b0);
    ed[0] = 64'hCCCC_CCC1_DDDD_DDD1;
    read_burst("rd4b", 4'd2, BASE + 64'h48, 8'd0, 2'b01, 1'b0);

    // w_last on the wrong beat: SLVERR, data still committed
    wd[0] = 64'h0102_0304_0506_0708; wd[1] = 64'h1112_1314_1516_1718;
    write_burst("wr4d", 4'd11, BASE + 64'h200, 8'd1, 2'b01, 6'd0, 0, 2'b10);
    ed[0] = 64'h0102_0304_0506_0708; ed[1] = 64'h1112_1314_1516_1718;
    read_burst("rd4d", 4'd12, BASE + 64'h200, 8'd1, 2'b01, 1'b0);

    // WRAP read and read past the end
    for (int k = 0; k < 8; k++) begin ed[k] = 64'd0; er[k] = 2'b10; end
    read_burst("rd5a", 4'd13, BASE + 64'h40, 8'd3, 2'b10, 1'b0);
    read_burst("rd5b", 4'd14, BASE + 64'h2000, 8'd1, 2'b01, 1'b0);
    for (int k = 0; k < 8; k++) er[k] = 2'b00;

    // reset during beat 2 of a len 3 write
    aw_valid = 1; aw_id = 4'd15; aw_addr = BASE + 64'h300; aw_len = 8'd3; aw_size = 3'd3;
    aw_burst = 2'b01; aw_atop = 6'd0;
    @(posedge clk); #1 aw_valid = 0;
    for (int k = 0; k < 2; k++) begin
      w_valid = 1; w_data = 64'h7700_0000_0000_0000 + 64'(k); w_strb = 8'hFF; w_last = 0;
      @(posedge clk); #1;
    end
    w_data = 64'h7700_0000_0000_0002; rst = 1; b_ready = 1;
    @(negedge clk); chk_idle_outputs("midrst");
    @(posedge clk); #1 rst = 0; w_valid = 0;
    @(negedge clk);
    chk("midrst_aw_ready", 64'(aw_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("midrst_no_b%0d", k), 64'(b_valid), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 b_ready = 0;
    ed[0] = 64'h7700_0000_0000_0000; ed[1] = 64'h7700_0000_0000_0001;
    read_burst("rd6", 4'd3, BASE + 64'h300, 8'd1, 2'b01, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
